// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous
// shadow update and optional leading-zero blanking.
module seven_seg_scanner #(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PC_W  = $clog2(DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(DIV - 1);

  logic [PC_W-1:0]       pc_q, pc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  run_q, run_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;
  logic [3:0]            nib;
  logic                  lz;
  logic                  blank;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    pc_d      = pc_q;
    idx_d     = idx_q;
    pend_d    = load ? data : pend_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    run_d     = en;
    fd_d      = 1'b0;

    // run_q marks the first enabled edge so digit 0 gets a full DIV-cycle slot
    if (!en) begin
      pc_d      = '0;
      idx_d     = '0;
      shadow_d  = pend_d;
      pending_d = 1'b0;
    end else if (!run_q) begin
      pc_d  = '0;
      idx_d = '0;
      if (load) pending_d = 1'b1;
    end else if (pc_q == LAST_PC) begin
      pc_d = '0;
      if (idx_q == LAST_IDX) begin
        idx_d     = '0;
        shadow_d  = pend_d;
        pending_d = 1'b0;
        fd_d      = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        if (load) pending_d = 1'b1;
      end
    end else begin
      pc_d = pc_q + PC_W'(1);
      if (load) pending_d = 1'b1;
    end

    nib   = 4'h0;
    lz    = 1'b1;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) nib = shadow_d[4*i +: 4];
    end
    // lz accumulates "all nibbles from i upward are zero", walking down from the top
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz = lz && (shadow_d[4*i +: 4] == 4'h0);
      if ((idx_d == IDX_W'(i)) && lz) blank = blank_lz;
    end

    an_d  = '1;
    seg_d = 7'h7F;
    if (en && !blank) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = (idx_d != IDX_W'(i));
      end
      seg_d = hex2seg(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      run_q     <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      fd_q      <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It accepts a packed hex value from the host logic and holds it in a pending register. At each frame boundary it transfers the pending value into a display shadow register, so a frame never shows half-old, half-new digits. It then scans the digits one at a time through a single shared hex-to-segment decode stage, and sits between the system datapath and the board's anode/segment pins.

## Interface
- DIGITS, 8: number of digits scanned, legal 1..8; data nibble i drives digit i.
- DIV, 50000: clock cycles per digit slot, legal ≥ 2.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; low blanks the display and parks the scan.
- load  input  1  one-cycle write strobe for data.
- data  input  4*DIGITS  packed hex value; nibble i = digit i, digit 0 rightmost.
- blank_lz  input  1  suppress leading zeros when high.
- an  output  DIGITS  anode enables, active-low, at most one bit low.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse at each frame wrap.
- pending  output  1  high while accepted data is not yet shown.

## Operation
- Registers: prescaler pc (0..DIV-1), digit index idx (0..DIGITS-1), pend_reg, shadow, pending flag. All outputs are registered.
- Load: load=1 captures data into pend_reg and sets pending. Back-to-back loads are legal; the last one wins.
- Scan (en=1):
  - pc increments every cycle.
  - When pc=DIV-1: pc←0 and idx←idx+1.
  - When pc=DIV-1 and idx=DIGITS-1, the frame wraps: idx←0, frame_done pulses, shadow←pend_reg, pending←0.
- Load on the wrap edge: shadow←data directly, pend_reg←data, pending stays 0. The new value is never lost or delayed a frame.
- Disabled (en=0):
  - pc←0, idx←0.
  - an all ones, seg=7'h7F, frame_done=0.
  - Every cycle shadow←pend_reg (or ←data when load=1), and pending←0.
- Decode, active-low standard hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Leading-zero blank: when blank_lz=1, digit i>0 is blanked if shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Output for the active idx:
  - Not blanked: an has only bit idx low; seg = decode(shadow nibble idx).
  - Blanked: an all ones, seg=7'h7F.
- DIGITS=1: idx is constant 0 and every slot is a frame wrap.

## Timing
- Reset values: an all ones, seg=7'h7F, frame_done=0, pending=0; pc=0, idx=0, pend_reg=0, shadow=0.
- an and seg are loaded on the same edge that updates idx and shadow, so they reflect the post-edge values with no extra latency.
- First active edge with en=1 after reset: an=~1 (digit 0 on), seg=7'h40.
- Each digit stays on for exactly DIV cycles. A frame lasts DIGITS*DIV cycles.
- frame_done is high for exactly one cycle per frame, coincident with the an change back to digit 0.
- load→visible latency is at most DIGITS*DIV cycles, and 1 cycle when en=0 or on the wrap edge.
- pending rises the cycle after load and falls the cycle after the wrap edge.
- rst_n asserted mid-frame immediately forces all reset values, including dropping an in-flight pending value. Scanning restarts at digit 0 with pc=0 after release.
- en falling mid-slot takes effect at the next edge. en rising starts a full DIV-cycle slot on digit 0.
- blank_lz is sampled every cycle with no synchronisation requirement.

## Test plan
- Reset then en=1, DIGITS=4, DIV=4, no load → an cycles 1110,1101,1011,0111 with 4 cycles each; seg=40 throughout; frame_done pulses every 16 cycles.
- Load data=16'hF8A1 mid-frame → pending=1 and segs unchanged until the wrap. After the wrap, digits 0..3 show 79,08,00,0E and pending=0.
- blank_lz=1, shadow=16'h0050 → digit 3 blanked (an 1111, seg 7F); digit 2 is also zero, so blanked; digit 1 shows 12; digit 0 shows 40. With blank_lz=0, all four digits are driven.
- Load asserted exactly on the wrap edge with data=16'h1234 → the following frame shows 1234 immediately and pending never rises.
- en=0 with load data=16'h00C0 → an all ones and seg=7F. Raising en → digit 0 (shows 40) is on for a full 4 cycles; digit 1 shows 46.
- rst_n pulsed low mid-slot on digit 2 with pending=1 → outputs return to reset values asynchronously, pending=0, and shadow=0 after release.
